output_arbiter: RTL and testbench
=================================

# output_arbiter

Round-robin output scheduler for one output port of the 4x4 crossbar. The block takes the four per-output request words that the input queues drive toward this port and returns a one-hot grant that pops the winning queue. It latches the winning data into a registered output stage with a valid/ready handshake. Four instances, one per output port, sit between the input queues and the output links. Each instance's grant bus feeds the matching grant input of every input queue.

## Interface
- width, 8, data bits per flit; request words are width+1 bits.
- BURST, 2, maximum consecutive grants to one input before priority rotates (legal range 1..15).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req0..req3  input  width+1 each  request from input queue i: bit [width] = valid, bits [width-1:0] = data.
- out_ready  input  1  downstream accepts out_data this cycle.
- grant  output  4  one-hot grant, combinational; bit i pops input queue i on this rising edge.
- out_data  output  width  registered flit.
- out_valid  output  1  out_data holds a flit.
- out_src  output  2  index of the input that supplied out_data.
- xfer_count  output  16  count of completed output handshakes; wraps.

## Operation
- Internal state:
  - ptr[1:0]: current priority input.
  - cnt[3:0]: consecutive grants issued to ptr.
- Reset values (while rst=0):
  - ptr=0, cnt=0.
  - out_valid=0, out_data=0, out_src=0, xfer_count=0.
  - grant forced to 0.
- The load enable is can_load = !out_valid || out_ready.
- Grant selection:
  - If can_load=0 or no reqi[width] is set, grant=0.
  - Otherwise, scan inputs ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first input with its valid bit set is the winner w, and grant = 1<<w.
- On a rising edge with grant!=0:
  - out_data <= req_w[width-1:0].
  - out_src <= w.
  - out_valid <= 1.
  - Compute n = (w==ptr) ? cnt+1 : 1.
  - If n >= BURST: ptr <= w+1 (mod 4) and cnt <= 0.
  - Else: ptr <= w and cnt <= n.
- On a rising edge with grant=0:
  - ptr and cnt hold.
  - If out_valid && out_ready, then out_valid <= 0. out_data and out_src hold their last value.
- xfer_count increments by 1 on every edge where out_valid && out_ready, wrapping from 16'hFFFF to 0.
- BURST=1 gives pure round-robin. A holder whose request drops loses priority to the next requester in scan order, with no idle cycle.
- Simultaneous pop and load: when out_valid=1 and out_ready=1 and a request is pending, a new flit loads on the same edge the old one leaves. out_valid stays 1.

## Timing
- Grant is a combinational function of req0..req3, out_valid, out_ready, ptr and cnt. There is no flop between request and grant.
- The granted flit appears on out_data and out_src one cycle after its grant, with out_valid=1.
- Throughput is one flit per cycle while out_ready=1 and any request is valid.
- Backpressure: while out_valid=1 and out_ready=0, grant=0 and the output register holds. The grant resumes in the same cycle out_ready rises.
- Reset asserted mid-operation:
  - Outputs clear immediately, not at the next edge.
  - Any flit in out_data is discarded.
  - Grant is 0 for the whole reset period, so no queue pops during reset.
- First edge after reset release: scan starts at input 0.

## Test plan
- Reset: hold rst=0 with all reqs valid. Required: grant=0000, out_valid=0, xfer_count=0. After release, the first grant is 0001.
- Single requester: req2={1,8'hCC}, others invalid, out_ready=1. Required: grant=0100 every cycle; from the next cycle, out_data=CC, out_src=2, out_valid=1; xfer_count increments each cycle.
- Full contention with BURST=2: req0..3 = AA, BB, CC, DD (all valid), out_ready=1. Required grant sequence: 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001. out_data follows one cycle later: AA, AA, BB, BB, ...
- Backpressure: after a load of AA, drive out_ready=0 for 3 cycles. Required: grant=0000 and out_data=AA held. Then out_ready=1: grant is nonzero in that same cycle, and xfer_count rises by exactly 1 for AA.
- Holder drop: req0 granted once (ptr=0, cnt=1), then req0 invalid while req1 and req3 are valid. Required: grant=0010 next, followed by 0010 again (BURST=2), then 1000.
- Async reset mid-stream: pull rst low between edges during full contention. Required: out_valid, grant and xfer_count go to 0 without waiting for a clock edge. After release, the sequence restarts at 0001.

Source files
------------

// File: rtl/output_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// output_arbiter_if : request/grant and output-link bundle for one output port
// Revision 1.0
// ----------------------------------------------------------------------------
interface output_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH:0]   req0;
  logic [WIDTH:0]   req1;
  logic [WIDTH:0]   req2;
  logic [WIDTH:0]   req3;
  logic             out_ready;
  logic [3:0]       grant;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [1:0]       out_src;
  logic [15:0]      xfer_count;

  modport master (
    input  req0, req1, req2, req3, out_ready,
    output grant, out_data, out_valid, out_src, xfer_count
  );

  modport slave (
    output req0, req1, req2, req3, out_ready,
    input  grant, out_data, out_valid, out_src, xfer_count
  );
endinterface
`default_nettype wire

// File: rtl/output_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// output_arbiter : burst-limited round-robin scheduler with registered output
// Revision 1.0
// ----------------------------------------------------------------------------
module output_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  output_arbiter_if.master   bus
);
  localparam logic [3:0] c_burst = 4'(BURST);

  logic [WIDTH:0]   w_req [4];
  logic [1:0]       r_ptr;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [1:0]       r_out_src;
  logic [15:0]      r_xfer_count;

  logic             w_can_load;
  logic             w_found;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic [3:0]       w_grant;
  logic             w_fire;
  logic             w_pop;
  logic [3:0]       w_n;

  assign w_req[0] = bus.req0;
  assign w_req[1] = bus.req1;
  assign w_req[2] = bus.req2;
  assign w_req[3] = bus.req3;

  assign w_can_load = !r_out_valid || bus.out_ready;
  assign w_pop      = r_out_valid && bus.out_ready;

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_req[w_idx][WIDTH]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Reset gates the grant directly so no queue pops while rst is low.
  assign w_grant = (rst && w_can_load && w_found) ? (4'b0001 << w_win) : 4'b0000;
  assign w_fire  = |w_grant;
  assign w_n     = (w_win == r_ptr) ? (r_cnt + 4'd1) : 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= 2'd0;
      r_cnt       <= 4'd0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= 2'd0;
    end else if (w_fire) begin
      r_out_data  <= w_req[w_win][WIDTH-1:0];
      r_out_src   <= w_win;
      r_out_valid <= 1'b1;
      if (w_n >= c_burst) begin
        r_ptr <= w_win + 2'd1;
        r_cnt <= 4'd0;
      end else begin
        r_ptr <= w_win;
        r_cnt <= w_n;
      end
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xfer_count <= 16'd0;
    end else if (w_pop) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign bus.grant      = w_grant;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_src    = r_out_src;
  assign bus.xfer_count = r_xfer_count;
endmodule
`default_nettype wire

// File: tb/tb_output_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_output_arbiter : directed and random checks against a scan-order model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_output_arbiter;
  localparam int WIDTH = 8;
  localparam int BURST = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] rq [4];
  logic       rdy;

  int passed = 0;
  int total  = 0;

  // reference state
  int m_ptr, m_cnt, m_valid, m_data, m_src, m_xfer;

  output_arbiter_if #(.WIDTH(WIDTH)) bus ();

  assign bus.req0      = rq[0];
  assign bus.req1      = rq[1];
  assign bus.req2      = rq[2];
  assign bus.req3      = rq[3];
  assign bus.out_ready = rdy;

  output_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_valid = 0; m_data = 0; m_src = 0; m_xfer = 0;
  endtask

  function automatic int model_win();
    if (!rst) return -1;
    if (m_valid != 0 && !rdy) return -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (rq[i][8]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input int w);
    int n;
    bit hs;
    hs = (m_valid != 0) && rdy;
    if (hs) m_xfer = (m_xfer + 1) % 65536;
    if (w >= 0) begin
      m_data  = int'(rq[w][7:0]);
      m_src   = w;
      m_valid = 1;
      n = (w == m_ptr) ? m_cnt + 1 : 1;
      if (n >= BURST) begin
        m_ptr = (w + 1) % 4;
        m_cnt = 0;
      end else begin
        m_ptr = w;
        m_cnt = n;
      end
    end else if (hs) begin
      m_valid = 0;
    end
  endtask

  // One clock cycle starting at a falling edge; exp_g < 0 means model-only.
  task automatic cycle(input string tag, input int exp_g);
    int w;
    logic [3:0] eg;
    #1;
    w  = model_win();
    eg = (w < 0) ? 4'b0000 : 4'(1 << w);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(eg));
    if (exp_g >= 0) chk({tag, ".grant_spec"}, 32'(bus.grant), 32'(exp_g));
    @(posedge clk);
    model_edge(w);
    #1;
    chk({tag, ".valid"}, 32'(bus.out_valid),  32'(m_valid));
    chk({tag, ".data"},  32'(bus.out_data),   32'(m_data));
    chk({tag, ".src"},   32'(bus.out_src),    32'(m_src));
    chk({tag, ".xfer"},  32'(bus.xfer_count), 32'(m_xfer));
    @(negedge clk);
  endtask

  task automatic set_reqs(input logic [3:0] v, input logic [31:0] d);
    for (int i = 0; i < 4; i++) rq[i] = {v[i], d[8*i +: 8]};
  endtask

  initial begin
    int seq [9] = '{1, 1, 2, 2, 4, 4, 8, 8, 1};
    int x0;

    // reset held with every input requesting
    model_reset();
    rdy = 1'b1;
    set_reqs(4'b1111, 32'hDDCCBBAA);
    @(negedge clk);
    @(negedge clk);
    chk("rst.grant", 32'(bus.grant), 32'd0);
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.xfer",  32'(bus.xfer_count), 32'd0);
    rst = 1'b1;

    // full contention, BURST=2
    for (int i = 0; i < 9; i++) cycle("contend", seq[i]);

    // asynchronous reset between edges
    rst = 1'b0;
    #1;
    chk("arst.grant", 32'(bus.grant), 32'd0);
    chk("arst.valid", 32'(bus.out_valid), 32'd0);
    chk("arst.xfer",  32'(bus.xfer_count), 32'd0);
    model_reset();
    @(negedge clk);
    chk("arst.hold_grant", 32'(bus.grant), 32'd0);
    rst = 1'b1;
    cycle("restart", 1);
    cycle("restart", 1);
    cycle("restart", 2);

    // single requester on input 2
    set_reqs(4'b0100, 32'h00CC0000);
    for (int i = 0; i < 4; i++) cycle("single", 4);
    chk("single.data", 32'(bus.out_data), 32'hCC);

    // backpressure with AA held
    set_reqs(4'b0001, 32'h000000AA);
    cycle("bp_load", 1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) cycle("bp_hold", 0);
    chk("bp.data", 32'(bus.out_data), 32'hAA);
    x0 = int'(bus.xfer_count);
    rdy = 1'b1;
    cycle("bp_resume", 1);
    chk("bp.xfer_step", 32'(bus.xfer_count), 32'((x0 + 1) % 65536));

    // holder drop: input 0 granted once, then 1 and 3 request
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    set_reqs(4'b0001, 32'h000000AA);
    cycle("drop_first", 1);
    set_reqs(4'b1010, 32'hDD00BB00);
    cycle("drop", 2);
    cycle("drop", 2);
    cycle("drop", 8);

    // random traffic and backpressure
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++)
        rq[i] = {($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 8'($urandom)};
      rdy = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      cycle("rand", -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
